// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle ARM data-processing sequencer around an external ALU.
// Optional DP_SEQ_SHIFT_REG_EN adds register-specified shifts (READ_S state).
module dp_sequencer #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_carry_in,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_nzvc,
  output logic [3:0]  flags,
  output logic        done,
  output logic        skipped,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_S, S_READ, S_EXEC, S_WB
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_instr, r_a, r_b, r_res;
  logic [3:0]  r_nzvc, r_flags;
  logic        r_shc, r_skip, r_err;
`ifdef DP_SEQ_SHIFT_REG_EN
  logic [7:0]  r_s;
`endif

  logic        w_accept, w_cond_ok, w_regsh, w_unsup;
  logic        w_arith, w_nowr, w_shc;
  logic [31:0] w_op2;
  logic [7:0]  w_amt;
  logic        w_unused_ok;

  function automatic logic [31:0] f_ror(
    input logic [31:0] v, input logic [4:0] n);
    f_ror = (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

  // returns {carry, value}; amount 0 passes value and carry through
  function automatic logic [32:0] f_shift(
    input logic [31:0] v, input logic [1:0] ty,
    input logic [7:0] amt, input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    t = '0;
    r = '0;
    if (amt == 8'd0) begin
      f_shift = {cin, v};
    end else begin
      case (ty)
        2'b00: begin
          t = {1'b0, v} << amt;
          f_shift = t;
        end
        2'b01: begin
          t = {v, 1'b0} >> amt;
          f_shift = {t[0], t[32:1]};
        end
        2'b10: begin
          t = $signed({v, 1'b0}) >>> amt;
          f_shift = {t[0], t[32:1]};
        end
        default: begin
          r = f_ror(v, amt[4:0]);
          f_shift = {r[31], r};
        end
      endcase
    end
  endfunction

  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_regsh  = ~instr[25] & instr[4];
`ifdef DP_SEQ_SHIFT_REG_EN
  assign w_unsup  = 1'b0;
`else
  assign w_unsup  = w_regsh;
`endif
  assign w_nowr   = (r_instr[24:23] == 2'b10);
  assign w_arith  = (r_instr[24:22] == 3'b001) ||
                    (r_instr[24:22] == 3'b010) ||
                    (r_instr[24:22] == 3'b011) ||
                    (r_instr[24:22] == 3'b101);
  assign w_unused_ok = ^{r_instr[27:26], r_instr[4]};

  always_comb begin
    w_cond_ok = 1'b0;
    case (instr[31:28])
      4'h0: w_cond_ok = r_flags[2];
      4'h1: w_cond_ok = ~r_flags[2];
      4'h2: w_cond_ok = r_flags[0];
      4'h3: w_cond_ok = ~r_flags[0];
      4'h4: w_cond_ok = r_flags[3];
      4'h5: w_cond_ok = ~r_flags[3];
      4'h6: w_cond_ok = r_flags[1];
      4'h7: w_cond_ok = ~r_flags[1];
      4'h8: w_cond_ok = r_flags[0] & ~r_flags[2];
      4'h9: w_cond_ok = ~r_flags[0] | r_flags[2];
      4'hA: w_cond_ok = (r_flags[3] == r_flags[1]);
      4'hB: w_cond_ok = (r_flags[3] != r_flags[1]);
      4'hC: w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[1]);
      4'hD: w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[1]);
      4'hE: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept && !w_unsup && w_cond_ok)
          w_next = w_regsh ? S_READ_S : S_READ;
      S_READ_S: w_next = S_READ;
      S_READ:   w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_op2 = r_b;
    w_shc = r_flags[0];
    w_amt = 8'd0;
    if (r_instr[25]) begin
      w_op2 = f_ror({24'd0, r_instr[7:0]}, {r_instr[11:8], 1'b0});
      w_shc = (r_instr[11:8] == 4'd0) ? r_flags[0] : w_op2[31];
    end
`ifdef DP_SEQ_SHIFT_REG_EN
    else if (r_instr[4]) begin
      {w_shc, w_op2} = f_shift(r_b, r_instr[6:5], r_s, r_flags[0]);
    end
`endif
    else if (r_instr[6:5] == 2'b11 && r_instr[11:7] == 5'd0) begin
      w_op2 = {r_flags[0], r_b[31:1]};
      w_shc = r_b[0];
    end else begin
      // LSR/ASR #0 encode a shift by 32
      w_amt = {3'd0, r_instr[11:7]};
      if (w_amt == 8'd0 && (r_instr[6:5] == 2'b01 || r_instr[6:5] == 2'b10))
        w_amt = 8'd32;
      {w_shc, w_op2} = f_shift(r_b, r_instr[6:5], w_amt, r_flags[0]);
    end
  end

  // addresses are presented one cycle ahead so data is ready when captured
  always_comb begin
    instr_ready  = (r_state == S_IDLE);
    rf_raddr_a   = 4'd0;
    rf_raddr_b   = 4'd0;
    rf_we        = 1'b0;
    rf_waddr     = 4'd0;
    rf_wdata     = 32'd0;
    alu_opcode   = 4'd0;
    alu_a        = 32'd0;
    alu_b        = 32'd0;
    alu_carry_in = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (instr_valid) begin
          rf_raddr_a = w_regsh ? instr[11:8] : instr[19:16];
          rf_raddr_b = instr[3:0];
        end
      S_READ_S, S_READ: begin
        rf_raddr_a = r_instr[19:16];
        rf_raddr_b = r_instr[3:0];
      end
      S_EXEC: begin
        alu_opcode   = r_instr[24:21];
        alu_a        = r_a;
        alu_b        = w_op2;
        alu_carry_in = r_flags[0];
      end
      S_WB: begin
        rf_we    = ~w_nowr;
        rf_waddr = r_instr[15:12];
        rf_wdata = r_res;
      end
      default: ;
    endcase
  end

  assign done    = r_skip | (r_state == S_WB);
  assign skipped = r_skip;
  assign err     = r_err;
  assign flags   = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_instr <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_res   <= 32'd0;
      r_nzvc  <= 4'd0;
      r_shc   <= 1'b0;
      r_flags <= RESET_FLAGS;
      r_skip  <= 1'b0;
      r_err   <= 1'b0;
`ifdef DP_SEQ_SHIFT_REG_EN
      r_s     <= 8'd0;
`endif
    end else begin
      r_state <= w_next;
      r_skip  <= w_accept & ~w_unsup & ~w_cond_ok;
      r_err   <= w_accept & w_unsup;
      if (w_accept) r_instr <= instr;
`ifdef DP_SEQ_SHIFT_REG_EN
      if (r_state == S_READ_S) r_s <= rf_rdata_a[7:0];
`endif
      if (r_state == S_READ) begin
        r_a <= rf_rdata_a;
        r_b <= rf_rdata_b;
      end
      if (r_state == S_EXEC) begin
        r_res  <= alu_result;
        r_nzvc <= alu_nzvc;
        r_shc  <= w_shc;
      end
      if (r_state == S_WB && (r_instr[20] || w_nowr))
        r_flags <= w_arith ? r_nzvc
                           : {r_nzvc[3:2], r_flags[1], r_shc};
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed bench for dp_sequencer with register bank,
// ALU model and an expected-result queue. Honours DP_SEQ_SHIFT_REG_EN.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_opcode, alu_nzvc, flags;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carry_in, done, skipped, err;

  always #5 clk = ~clk;

  dp_sequencer #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .alu_nzvc(alu_nzvc), .flags(flags),
    .done(done), .skipped(skipped), .err(err)
  );

  // register bank with one-cycle read latency, plus a bench load port
  logic [31:0] regs [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_a = 4'd0;
  logic [31:0] ld_d = 32'd0;
  int          n_wr = 0;

  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      n_wr <= n_wr + 1;
    end
    if (ld_en) regs[ld_a] <= ld_d;
  end

  // reference ALU
  logic [31:0] m_x, m_y, m_r;
  logic [32:0] m_s;
  logic        m_ci, m_ar;

  always_comb begin
    m_x = alu_a;
    m_y = alu_b;
    m_ci = 1'b0;
    m_ar = 1'b0;
    m_r = 32'd0;
    case (alu_opcode)
      4'h2, 4'hA: begin m_y = ~alu_b; m_ci = 1'b1; m_ar = 1'b1; end
      4'h3: begin m_x = alu_b; m_y = ~alu_a; m_ci = 1'b1; m_ar = 1'b1; end
      4'h4, 4'hB: m_ar = 1'b1;
      4'h5: begin m_ci = alu_carry_in; m_ar = 1'b1; end
      4'h6: begin m_y = ~alu_b; m_ci = alu_carry_in; m_ar = 1'b1; end
      4'h7: begin
        m_x = alu_b; m_y = ~alu_a; m_ci = alu_carry_in; m_ar = 1'b1;
      end
      default: ;
    endcase
    m_s = {1'b0, m_x} + {1'b0, m_y} + {32'd0, m_ci};
    case (alu_opcode)
      4'h0, 4'h8: m_r = alu_a & alu_b;
      4'h1, 4'h9: m_r = alu_a ^ alu_b;
      4'hC: m_r = alu_a | alu_b;
      4'hD: m_r = alu_b;
      4'hE: m_r = alu_a & ~alu_b;
      4'hF: m_r = ~alu_b;
      default: m_r = m_s[31:0];
    endcase
    alu_result = m_r;
    alu_nzvc = {m_r[31], m_r == 32'd0,
                m_ar & (m_x[31] == m_y[31]) & (m_r[31] != m_x[31]),
                m_ar & m_s[32]};
  end

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        sk;
    logic        er;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input logic we, input logic [3:0] wa,
                              input logic [31:0] wd, input logic sk,
                              input logic er, input logic [3:0] fl,
                              input int lat);
    exp_t e;
    e.we = we; e.wa = wa; e.wd = wd;
    e.sk = sk; e.er = er; e.fl = fl; e.lat = lat;
    return e;
  endfunction

  function automatic logic [31:0] dp(input logic [3:0] c, input logic i,
                                     input logic [3:0] op, input logic s,
                                     input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] o2);
    return {c, 2'b00, i, op, s, rn, rd, o2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] ins,
                       input exp_t e);
    exp_t x;
    int lat, w0;
    @(negedge clk);
    chk({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    sb.push_back(e);
    w0 = n_wr;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'd0;
    lat = 1;
    while (!(done || err) && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    x = sb.pop_front();
    chk({tag, " latency"}, lat, x.lat);
    chk({tag, " done"}, {31'd0, done}, {31'd0, ~x.er});
    chk({tag, " skipped"}, {31'd0, skipped}, {31'd0, x.sk});
    chk({tag, " err"}, {31'd0, err}, {31'd0, x.er});
    chk({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, x.we});
    if (x.we) begin
      chk({tag, " waddr"}, {28'd0, rf_waddr}, {28'd0, x.wa});
      chk({tag, " wdata"}, rf_wdata, x.wd);
    end
    @(negedge clk);
    chk({tag, " flags"}, {28'd0, flags}, {28'd0, x.fl});
    chk({tag, " writes"}, n_wr - w0, {31'd0, x.we});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    #2;
    chk("rst ready", {31'd0, instr_ready}, 32'd1);
    chk("rst flags", {28'd0, flags}, 32'd0);
    chk("rst done", {29'd0, done, skipped, err}, 32'd0);
    chk("rst rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    setr(4'd0, 32'h7FFF_FFFF);
    setr(4'd1, 32'h0000_0001);
    issue("ADDS", dp(4'hE, 1'b0, 4'h4, 1'b1, 4'd0, 4'd2, 12'h001),
          mk(1'b1, 4'd2, 32'h8000_0000, 1'b0, 1'b0, 4'b1010, 3));

    setr(4'd0, 32'd5);
    setr(4'd1, 32'h8000_0000);
    issue("TST_LSR0", dp(4'hE, 1'b0, 4'h8, 1'b1, 4'd0, 4'd0, 12'h021),
          mk(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'b0111, 3));

    setr(4'd3, 32'd1);
    issue("SUBS_IMM", dp(4'hE, 1'b1, 4'h2, 1'b1, 4'd3, 4'd3, 12'h001),
          mk(1'b1, 4'd3, 32'd0, 1'b0, 1'b0, 4'b0101, 3));

    setr(4'd4, 32'h0000_1234);
    issue("MOVNE", dp(4'h1, 1'b1, 4'hD, 1'b0, 4'd0, 4'd4, 12'h005),
          mk(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'b0101, 1));
    chk("MOVNE r4 kept", regs[4], 32'h0000_1234);

    setr(4'd1, 32'd5);
    issue("CMP", dp(4'hE, 1'b0, 4'hA, 1'b1, 4'd0, 4'd0, 12'h001),
          mk(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'b0101, 3));

    issue("MOVS_ROT", dp(4'hE, 1'b1, 4'hD, 1'b1, 4'd0, 4'd5, 12'h4FF),
          mk(1'b1, 4'd5, 32'hFF00_0000, 1'b0, 1'b0, 4'b1001, 3));

    setr(4'd0, 32'd1);
    setr(4'd1, 32'd1);
    issue("ADC", dp(4'hE, 1'b0, 4'h5, 1'b0, 4'd0, 4'd6, 12'h001),
          mk(1'b1, 4'd6, 32'd3, 1'b0, 1'b0, 4'b1001, 3));
    issue("ADDMI", dp(4'h4, 1'b0, 4'h4, 1'b0, 4'd0, 4'd12, 12'h001),
          mk(1'b1, 4'd12, 32'd2, 1'b0, 1'b0, 4'b1001, 3));

    setr(4'd1, 32'd2);
    issue("RRX", dp(4'hE, 1'b0, 4'hD, 1'b1, 4'd0, 4'd9, 12'h061),
          mk(1'b1, 4'd9, 32'h8000_0001, 1'b0, 1'b0, 4'b1000, 3));

    setr(4'd1, 32'h8000_0000);
    issue("ASR0", dp(4'hE, 1'b0, 4'hD, 1'b1, 4'd0, 4'd10, 12'h041),
          mk(1'b1, 4'd10, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1001, 3));

    setr(4'd8, 32'd33);
    setr(4'd1, 32'hFFFF_FFFF);
`ifdef DP_SEQ_SHIFT_REG_EN
    issue("LSL_REG33", dp(4'hE, 1'b0, 4'hD, 1'b1, 4'd0, 4'd7, 12'h811),
          mk(1'b1, 4'd7, 32'd0, 1'b0, 1'b0, 4'b0100, 4));
    setr(4'd8, 32'd32);
    setr(4'd1, 32'h8000_0001);
    issue("LSR_REG32", dp(4'hE, 1'b0, 4'hD, 1'b1, 4'd0, 4'd7, 12'h831),
          mk(1'b1, 4'd7, 32'd0, 1'b0, 1'b0, 4'b0101, 4));
`else
    setr(4'd7, 32'h0000_0055);
    issue("LSL_REG_ERR", dp(4'hE, 1'b0, 4'hD, 1'b1, 4'd0, 4'd7, 12'h811),
          mk(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'b1001, 1));
    chk("REG_ERR r7 kept", regs[7], 32'h0000_0055);
`endif

    setr(4'd11, 32'h0000_DEAD);
    setr(4'd0, 32'd1);
    setr(4'd1, 32'd1);
    w0 = n_wr;
    @(negedge clk);
    instr = dp(4'hE, 1'b0, 4'h4, 1'b1, 4'd0, 4'd11, 12'h001);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("RST_EXEC ready", {31'd0, instr_ready}, 32'd1);
    chk("RST_EXEC flags", {28'd0, flags}, 32'd0);
    chk("RST_EXEC rf_we", {31'd0, rf_we}, 32'd0);
    chk("RST_EXEC alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("RST_EXEC writes", n_wr - w0, 32'd0);
    chk("RST_EXEC done", {31'd0, done}, 32'd0);
    chk("RST_EXEC r11 kept", regs[11], 32'h0000_DEAD);

    issue("ADDS_POST", dp(4'hE, 1'b0, 4'h4, 1'b1, 4'd0, 4'd13, 12'h001),
          mk(1'b1, 4'd13, 32'd2, 1'b0, 1'b0, 4'b0000, 3));
    issue("MOVCS", dp(4'h2, 1'b1, 4'hD, 1'b0, 4'd0, 4'd14, 12'h007),
          mk(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'b0000, 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
